ram_1w1r_1c_secded: RTL and testbench
=====================================

Name: ram_1w1r_1c_secded

Overview:
Simple dual-port RAM: one write port, one read port, single clock. Each word is protected by a SECDED Hamming code. An init sequencer clears the whole array after reset. Sticky error counters and an error-address register feed RFG status registers. The block replaces the plain 1w1r RAM wherever register-file memories need real sec/ded reporting.

Parameters:
DATASIZE, 64, user data word width (>=4)
ADDRSIZE, 9, address bits; depth = 2**ADDRSIZE
PIPELINED, 0, 0: rdata 1 cycle after ren; 1: extra register stage after the decoder, 2 cycles
INIT_ON_RESET, 1, 1: zero-fill the array (valid codewords) after reset; 0: skip the fill
BYPASS, 1, 1: a read and write to the same address in the same cycle returns the new wdata; 0: returns the old contents
CNTSIZE, 16, width of the error counters

Ports:
clk  in  1  clock, all logic on rising edge
res_n  in  1  synchronous active-low reset
wen  in  1  write enable
waddr  in  ADDRSIZE  write address
wdata  in  DATASIZE  write data
err_inj  in  2  test only; bit0 flips codeword bit 0, bit1 flips codeword bit 1, applied on this write
ren  in  1  read enable
raddr  in  ADDRSIZE  read address
rdata  out  DATASIZE  corrected read data
rvalid  out  1  one-cycle pulse marking rdata/sec/ded valid
sec  out  1  single-bit error corrected on this read
ded  out  1  double-bit error detected on this read
init_done  out  1  high once the array is usable
cnt_clr  in  1  clears sec_cnt and ded_cnt
sec_cnt  out  CNTSIZE  saturating count of sec events
ded_cnt  out  CNTSIZE  saturating count of ded events
err_addr  out  ADDRSIZE  raddr of the most recent sec or ded read

Behaviour:
- Reset is synchronous and active-low: res_n is sampled low at a clk edge. It clears rdata, rvalid, sec, ded, sec_cnt, ded_cnt, err_addr and the init address counter to 0. The array contents are not reset.
- Codeword width:
  - P = smallest value with 2**P >= DATASIZE+P+1.
  - Codeword = DATASIZE + P + 1 bits, the extra bit being overall parity (72 bits for 64-bit data).
  - Check bits sit at power-of-two positions; overall parity is the MSB of the codeword.
- FSM states INIT and RUN:
  - After reset: INIT if INIT_ON_RESET=1, else RUN.
  - INIT writes the encoded all-zero word to address cnt, one address per cycle, cnt = 0 .. 2**ADDRSIZE-1, then moves to RUN.
  - During INIT: wen, ren and err_inj are ignored, rvalid stays 0, init_done=0.
  - In RUN: init_done=1.
  - Reset asserted mid-INIT restarts the fill at address 0.
- Write:
  - Takes effect at the clk edge where wen=1.
  - The stored codeword is the encoded wdata XOR {err_inj bits on codeword positions 0,1}.
- Read pipeline:
  - The array read is registered at the clk edge where ren=1 (BRAM-inferable).
  - The syndrome decode follows the array read.
  - PIPELINED=0: rdata/sec/ded/rvalid appear in cycle N+1 for ren in cycle N.
  - PIPELINED=1: they appear in cycle N+2.
  - Back-to-back reads are accepted every cycle.
- Read results:
  - rdata holds its last value when no read completes. rvalid, sec and ded are 0 in any cycle without a completing read.
  - Syndrome 0, parity OK: clean read.
  - Syndrome !=0, parity bad: flip the indicated bit (data or check), sec=1.
  - Syndrome 0, parity bad: the parity bit itself is in error; sec=1, data unchanged.
  - Syndrome !=0, parity OK: ded=1, rdata = uncorrected data bits.
  - Syndrome pointing outside the codeword: treated as ded.
- Read-during-write, same address, same cycle:
  - BYPASS=1: rdata = wdata, sec=ded=0, err_inj not reflected.
  - BYPASS=0: old contents, decoded normally.
  - Different addresses: independent.
- Counters:
  - A counter increments on each completing read with its flag set and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; that event is lost from the count.
- err_addr:
  - Updated with the raddr of the completing read whenever sec or ded is set.
  - raddr travels alongside the read pipeline.
  - Not cleared by cnt_clr.

Test Plan:
- Init sweep: reset, then release res_n with ADDRSIZE=4 -> init_done rises exactly 16 cycles later; ren during the fill gives no rvalid; a later read of every address -> rdata=0, sec=ded=0.
- Basic R/W: write 0xDEADBEEF_01234567 to addr 5, read addr 5 -> rvalid and rdata at N+1 (PIPELINED=0) or N+2 (PIPELINED=1), sec=ded=0.
- Single-bit error: write 0xA5 pattern with err_inj=2'b01, read -> rdata=0xA5 pattern, sec=1, sec_cnt=1, err_addr=addr.
- Double-bit error: write with err_inj=2'b11 to addr 9, read -> ded=1, sec=0, ded_cnt=1, err_addr=9.
- Collision: same addr, wen+ren in one cycle, old=0x1, new=0x2 -> BYPASS=1 gives 0x2; BYPASS=0 gives 0x1.
- Counters and reset: CNTSIZE=2, 5 sec reads -> sec_cnt=3; cnt_clr on the same cycle as a sec read -> sec_cnt=0; res_n low mid-INIT -> fill restarts and init_done stays 0 for a full depth of cycles.

Source files
------------

// File: rtl/ram_1w1r_1c_secded.sv
// Simple dual-port RAM (1 write, 1 read, single clock) with per-word SECDED
// protection, post-reset zero fill, sticky error counters and error address.
module ram_1w1r_1c_secded #(
  parameter int unsigned DATASIZE      = 64,
  parameter int unsigned ADDRSIZE      = 9,
  parameter int unsigned PIPELINED     = 0,
  parameter int unsigned INIT_ON_RESET = 1,
  parameter int unsigned BYPASS        = 1,
  parameter int unsigned CNTSIZE       = 16
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic                wen,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [1:0]          err_inj,
  input  logic                ren,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata,
  output logic                rvalid,
  output logic                sec,
  output logic                ded,
  output logic                init_done,
  input  logic                cnt_clr,
  output logic [CNTSIZE-1:0]  sec_cnt,
  output logic [CNTSIZE-1:0]  ded_cnt,
  output logic [ADDRSIZE-1:0] err_addr
);

  // Smallest P with 2**P >= dw + P + 1
  function automatic int unsigned secded_p(input int unsigned dw);
    int unsigned p;
    p = 1;
    for (int i = 31; i >= 1; i--) begin
      if ((64'd1 << i) >= (64'(dw) + 64'(i) + 64'd1)) p = 32'(i);
    end
    return p;
  endfunction

  localparam int unsigned P     = secded_p(DATASIZE);
  localparam int unsigned HW    = DATASIZE + P;        // Hamming part, positions 1..HW
  localparam int unsigned CW    = HW + 1;              // plus overall parity in the MSB
  localparam int unsigned DEPTH = 1 << ADDRSIZE;

  // Data bits fill the non-power-of-two positions; check bits make the
  // XOR of all set positions zero; MSB is even parity over the rest.
  function automatic logic [CW-1:0] secded_enc(input logic [DATASIZE-1:0] d);
    logic [CW-1:0] cw;
    logic [P-1:0]  s;
    int            k;
    cw = '0;
    s  = '0;
    k  = 0;
    for (int pos = 1; pos <= int'(HW); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[k];
        if (d[k]) s = s ^ P'(pos);
        k++;
      end
    end
    for (int j = 0; j < int'(P); j++) cw[(1 << j) - 1] = s[j];
    cw[CW-1] = ^cw[HW-1:0];
    return cw;
  endfunction

  // Pull the data bits back out of a codeword
  function automatic logic [DATASIZE-1:0] secded_data(input logic [CW-1:0] cw);
    logic [DATASIZE-1:0] d;
    int                  k;
    d = '0;
    k = 0;
    for (int pos = 1; pos <= int'(HW); pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q;
  logic [ADDRSIZE-1:0] init_cnt_q;
  logic [CW-1:0]       mem [DEPTH];

  logic                in_init, mem_we, rd_go;
  logic [ADDRSIZE-1:0] mem_wa;
  logic [CW-1:0]       mem_wd;

  logic                rd_vld_q, byp_q;
  logic [CW-1:0]       rd_cw_q;
  logic [ADDRSIZE-1:0] rd_addr_q;
  logic [DATASIZE-1:0] byp_data_q;

  logic [P-1:0]        syn;
  logic                par_bad, dec_sec, dec_ded;
  logic [CW-1:0]       fix_cw;
  logic [DATASIZE-1:0] dec_data;

  logic                out_vld, out_sec, out_ded;
  logic [DATASIZE-1:0] out_data;
  logic [ADDRSIZE-1:0] out_addr;

  logic [CNTSIZE-1:0]  sec_cnt_q, ded_cnt_q;
  logic [ADDRSIZE-1:0] err_addr_q;

  // Init sequencer: sweep every address once, then hand over to user traffic
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      init_cnt_q <= '0;
    end else if (state_q == S_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_cnt_q == '1) state_q <= S_RUN;
    end
  end

  assign in_init   = (state_q == S_INIT);
  assign init_done = (state_q == S_RUN);
  assign mem_we    = res_n & (in_init | wen);
  assign mem_wa    = in_init ? init_cnt_q : waddr;
  assign mem_wd    = in_init ? secded_enc(DATASIZE'(0))
                             : (secded_enc(wdata) ^ CW'(err_inj));
  assign rd_go     = ren & ~in_init;

  // Array write port, shared by the fill and user writes
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Registered array read; captures are held between reads so rdata holds
  always_ff @(posedge clk) begin
    if (!res_n) begin
      rd_vld_q   <= 1'b0;
      rd_cw_q    <= '0;
      rd_addr_q  <= '0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_vld_q <= rd_go;
      if (rd_go) begin
        rd_cw_q    <= mem[raddr];
        rd_addr_q  <= raddr;
        byp_q      <= (BYPASS != 0) && wen && (waddr == raddr);
        byp_data_q <= wdata;
      end
    end
  end

  // Syndrome decode and correction of the captured codeword
  always_comb begin
    syn = '0;
    for (int pos = 1; pos <= int'(HW); pos++) begin
      if (rd_cw_q[pos-1]) syn = syn ^ P'(pos);
    end
    par_bad = ^rd_cw_q;
    fix_cw  = rd_cw_q;
    dec_sec = 1'b0;
    dec_ded = 1'b0;
    if (par_bad) begin
      if (int'(syn) > int'(HW)) begin
        dec_ded = 1'b1;
      end else begin
        // syn==0 means the parity bit itself flipped: nothing to fix here
        dec_sec = 1'b1;
        for (int pos = 1; pos <= int'(HW); pos++) begin
          if (pos == int'(syn)) fix_cw[pos-1] = ~fix_cw[pos-1];
        end
      end
    end else if (syn != '0) begin
      dec_ded = 1'b1;
    end
    dec_data = secded_data(fix_cw);
    if (byp_q) begin
      dec_data = byp_data_q;
      dec_sec  = 1'b0;
      dec_ded  = 1'b0;
    end
  end

  generate
    if (PIPELINED != 0) begin : g_pipe
      // Extra register stage after the decoder
      always_ff @(posedge clk) begin
        if (!res_n) begin
          out_vld  <= 1'b0;
          out_sec  <= 1'b0;
          out_ded  <= 1'b0;
          out_data <= '0;
          out_addr <= '0;
        end else begin
          out_vld <= rd_vld_q;
          out_sec <= rd_vld_q & dec_sec;
          out_ded <= rd_vld_q & dec_ded;
          if (rd_vld_q) begin
            out_data <= dec_data;
            out_addr <= rd_addr_q;
          end
        end
      end
    end else begin : g_direct
      assign out_vld  = rd_vld_q;
      assign out_sec  = rd_vld_q & dec_sec;
      assign out_ded  = rd_vld_q & dec_ded;
      assign out_data = dec_data;
      assign out_addr = rd_addr_q;
    end
  endgenerate

  // Saturating error counters (clear wins) and last-error address
  always_ff @(posedge clk) begin
    if (!res_n) begin
      sec_cnt_q  <= '0;
      ded_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      if (cnt_clr) begin
        sec_cnt_q <= '0;
        ded_cnt_q <= '0;
      end else begin
        if (out_sec && !(&sec_cnt_q)) sec_cnt_q <= sec_cnt_q + 1'b1;
        if (out_ded && !(&ded_cnt_q)) ded_cnt_q <= ded_cnt_q + 1'b1;
      end
      if (out_sec || out_ded) err_addr_q <= out_addr;
    end
  end

  assign rdata    = out_data;
  assign rvalid   = out_vld;
  assign sec      = out_sec;
  assign ded      = out_ded;
  assign sec_cnt  = sec_cnt_q;
  assign ded_cnt  = ded_cnt_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_1w1r_1c_secded.sv
// Scoreboard bench for ram_1w1r_1c_secded: directed vectors push expected read
// responses; a negedge monitor pops and compares whenever rvalid is seen.
`timescale 1ns/1ps
module tb_ram_1w1r_1c_secded;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNTW  = 2;
  localparam int unsigned PIPE  = 0;
  localparam int unsigned BYP   = 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LAT   = 1 + PIPE;

  localparam logic [DW-1:0] D_BEEF = 64'hDEADBEEF_01234567;
  localparam logic [DW-1:0] D_A5   = 64'hA5A5A5A5_A5A5A5A5;
  localparam logic [DW-1:0] D_DED  = 64'h0000_0000_0000_1234;

  logic            clk = 1'b0;
  logic            res_n = 1'b0;
  logic            wen = 1'b0;
  logic [AW-1:0]   waddr = '0;
  logic [DW-1:0]   wdata = '0;
  logic [1:0]      err_inj = '0;
  logic            ren = 1'b0;
  logic [AW-1:0]   raddr = '0;
  logic [DW-1:0]   rdata;
  logic            rvalid, sec, ded, init_done;
  logic            cnt_clr = 1'b0;
  logic [CNTW-1:0] sec_cnt, ded_cnt;
  logic [AW-1:0]   err_addr;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sec;
    logic          ded;
    logic [31:0]   cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;

  ram_1w1r_1c_secded #(
    .DATASIZE(DW), .ADDRSIZE(AW), .PIPELINED(PIPE),
    .INIT_ON_RESET(1), .BYPASS(BYP), .CNTSIZE(CNTW)
  ) dut (
    .clk(clk), .res_n(res_n), .wen(wen), .waddr(waddr), .wdata(wdata),
    .err_inj(err_inj), .ren(ren), .raddr(raddr), .rdata(rdata),
    .rvalid(rvalid), .sec(sec), .ded(ded), .init_done(init_done),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
  endtask

  // One cycle of stimulus; a read pushes its expected response
  task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [1:0] inj, input logic r, input logic [AW-1:0] ra,
                    input logic [DW-1:0] ed, input logic es, input logic edd);
    exp_t e;
    wen = w; waddr = wa; wdata = wd; err_inj = inj;
    ren = r; raddr = ra;
    if (r) begin
      e.data = ed; e.sec = es; e.ded = edd; e.cyc = cyc + LAT;
      sb.push_back(e);
    end
    step();
    wen = 1'b0; ren = 1'b0; err_inj = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] inj);
    op(1'b1, a, d, inj, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic es, input logic edd);
    op(1'b0, '0, '0, 2'b00, 1'b1, a, ed, es, edd);
  endtask

  // Release reset and watch init_done rise after exactly DEPTH edges
  task automatic release_fill(input logic rd_during);
    ren = rd_during;
    raddr = 4'd2;
    res_n = 1'b1;
    for (int i = 1; i <= int'(DEPTH); i++) begin
      step();
      chk("init_done_sweep", 64'(init_done), 64'(i == int'(DEPTH)));
    end
    ren = 1'b0;
  endtask

  // Monitor: pop and compare on every completing read
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rvalid: rvalid=1 at cycle %0d, required 0 (no read outstanding)", cyc);
        end else begin
          e = sb.pop_front();
          chk("rdata", rdata, e.data);
          chk("sec", 64'(sec), 64'(e.sec));
          chk("ded", 64'(ded), 64'(e.ded));
          chk("latency", 64'(cyc), 64'(e.cyc));
        end
      end else if (res_n) begin
        chk("idle_flags", 64'({sec, ded}), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    res_n = 1'b0;
    idle(3);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_sec_cnt", 64'(sec_cnt), 64'd0);
    chk("rst_ded_cnt", 64'(ded_cnt), 64'd0);
    chk("rst_err_addr", 64'(err_addr), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);

    // Fill with ren held high: no rvalid may appear
    release_fill(1'b1);
    for (int a = 0; a < int'(DEPTH); a++) rd(AW'(a), '0, 1'b0, 1'b0);
    idle(LAT + 2);
    chk("sb_empty_sweep", 64'(sb.size()), 64'd0);

    // Basic write/read
    wr(4'd5, D_BEEF, 2'b00);
    rd(4'd5, D_BEEF, 1'b0, 1'b0);

    // Single-bit error on a check bit: corrected, counted
    wr(4'd7, D_A5, 2'b01);
    rd(4'd7, D_A5, 1'b1, 1'b0);
    idle(LAT + 1);
    chk("sec_cnt_1", 64'(sec_cnt), 64'd1);
    chk("ded_cnt_0", 64'(ded_cnt), 64'd0);
    chk("err_addr_7", 64'(err_addr), 64'd7);

    // Double-bit error: detected, data passed uncorrected
    wr(4'd9, D_DED, 2'b11);
    rd(4'd9, D_DED, 1'b0, 1'b1);
    idle(LAT + 1);
    chk("ded_cnt_1", 64'(ded_cnt), 64'd1);
    chk("sec_cnt_still_1", 64'(sec_cnt), 64'd1);
    chk("err_addr_9", 64'(err_addr), 64'd9);

    // Same-address collision, then a clean re-read of the new value
    wr(4'd3, 64'd1, 2'b00);
    op(1'b1, 4'd3, 64'd2, 2'b00, 1'b1, 4'd3, (BYP != 0) ? 64'd2 : 64'd1, 1'b0, 1'b0);
    rd(4'd3, 64'd2, 1'b0, 1'b0);
    // Different addresses in the same cycle stay independent
    op(1'b1, 4'd4, 64'h44, 2'b00, 1'b1, 4'd5, D_BEEF, 1'b0, 1'b0);
    rd(4'd4, 64'h44, 1'b0, 1'b0);
    idle(LAT + 1);
    chk("err_addr_kept_9", 64'(err_addr), 64'd9);

    // Saturation at all-ones
    repeat (5) rd(4'd7, D_A5, 1'b1, 1'b0);
    idle(LAT + 1);
    chk("sec_cnt_sat", 64'(sec_cnt), 64'd3);

    // Standalone clear, then one event, then clear colliding with an event
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sec_cnt_clr", 64'(sec_cnt), 64'd0);
    chk("ded_cnt_clr", 64'(ded_cnt), 64'd0);
    rd(4'd7, D_A5, 1'b1, 1'b0);
    idle(LAT + 1);
    chk("sec_cnt_after_clr", 64'(sec_cnt), 64'd1);
    rd(4'd7, D_A5, 1'b1, 1'b0);
    idle(LAT - 1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    idle(1);
    chk("sec_cnt_clr_prio", 64'(sec_cnt), 64'd0);
    chk("err_addr_not_cleared", 64'(err_addr), 64'd7);
    chk("sb_empty_mid", 64'(sb.size()), 64'd0);

    // Reset, partial fill, reset again mid-INIT: fill restarts from 0
    res_n = 1'b0;
    step();
    chk("rst2_err_addr", 64'(err_addr), 64'd0);
    chk("rst2_rdata", rdata, 64'd0);
    chk("rst2_init_done", 64'(init_done), 64'd0);
    res_n = 1'b1;
    idle(8);
    chk("mid_init_done", 64'(init_done), 64'd0);
    res_n = 1'b0;
    step();
    release_fill(1'b0);
    rd(4'd5, 64'd0, 1'b0, 1'b0);
    rd(4'd7, 64'd0, 1'b0, 1'b0);
    idle(LAT + 2);
    chk("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
